// File: rtl/ahb_slave_mux.sv
// rtl/ahb_slave_mux.sv - AHB slave multiplexer with DES slave decode and built-in default slave
//
// Purpose: decodes the AHB address phase into a DES slave select and registers
// the select for the data phase. The data-phase response (HREADY/HRESP/HRDATA)
// is muxed from the DES slave, a zero-wait OKAY for idle/busy transfers, or a
// built-in default slave that answers unmapped transfers with a two-cycle ERROR.
//
// Optional feature: define AHB_MUX_ERRCNT_EN to add the ERR_COUNT output,
// a saturating count of ERROR responses started by the default slave.
//
// Ports:
//   HCLK           in   1   clock, all state on rising edge
//   HRESET         in   1   asynchronous active-high reset
//   HADDR          in  32   address-phase address
//   HTRANS         in   2   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HSEL_DES       out  1   address-phase select to DES slave
//   HREADYOUT_DES  in   1   DES slave ready
//   HRESP_DES      in   1   DES slave response
//   HRDATA_DES     in  64   DES slave read data
//   HREADY         out  1   muxed ready (to master and all slaves)
//   HRESP          out  1   muxed response (0 OKAY, 1 ERROR)
//   HRDATA         out 64   muxed read data
//   ERR_COUNT      out  8   unmapped-access error count (AHB_MUX_ERRCNT_EN only)

module ahb_slave_mux #(
  parameter logic [31:0] DES_BASE = 32'h8000_0000,
  parameter logic [31:0] DES_MASK = 32'hFFFF_F000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HSEL_DES,
  input  logic        HREADYOUT_DES,
  input  logic        HRESP_DES,
  input  logic [63:0] HRDATA_DES,
  output logic        HREADY,
  output logic        HRESP,
  output logic [63:0] HRDATA
`ifdef AHB_MUX_ERRCNT_EN
  ,
  output logic [7:0]  ERR_COUNT
`endif
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DES  = 2'd1,
    SEL_DEF  = 2'd2
  } dsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  dsel_e  dsel_q, dsel_d;
  state_e state_q, state_d;

  logic htrans_active;
  logic def_capture;

  assign HSEL_DES      = ((HADDR & DES_MASK) == (DES_BASE & DES_MASK));
  assign htrans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // A transfer is only accepted while HREADY is high; a held address during
  // wait states is never re-decoded into the data-phase select or the FSM.
  assign def_capture = HREADY && !HSEL_DES && htrans_active;

  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) begin
      if (HSEL_DES)           dsel_d = SEL_DES;
      else if (htrans_active) dsel_d = SEL_DEF;
      else                    dsel_d = SEL_NONE;
    end
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q  <= SEL_NONE;
      state_q <= ST_IDLE;
    end else begin
      dsel_q  <= dsel_d;
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = def_capture ? ST_ERR1 : ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = def_capture ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: data-phase mux
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 64'd0;
    case (dsel_q)
      SEL_DES: begin
        HREADY = HREADYOUT_DES;
        HRESP  = HRESP_DES;
        HRDATA = HRDATA_DES;
      end
      SEL_DEF: begin
        // ERR1 stalls with ERROR, ERR2 completes the ERROR.
        case (state_q)
          ST_ERR1: begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
          end
          ST_ERR2: begin
            HREADY = 1'b1;
            HRESP  = 1'b1;
          end
          default: begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
          end
        endcase
      end
      default: begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end
    endcase
  end

`ifdef AHB_MUX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // ERR1 always leaves to ERR2, so entering ERR1 is exactly state_d == ERR1.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_d == ST_ERR1) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign ERR_COUNT = err_count_q;
`endif

endmodule

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

Interface
REQ-001 Parameter DES_BASE, default 32'h8000_0000, base address of the DES slave region.
REQ-002 Parameter DES_MASK, default 32'hFFFF_F000, address bits compared against DES_BASE.
REQ-003 HCLK  in  1  system clock; one clock; all state on rising edge.
REQ-004 HRESET  in  1  reset, asynchronous, active-high.
REQ-005 HADDR  in  32  master address-phase address.
REQ-006 HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 HSEL_DES  out  1  address-phase select to DES slave.
REQ-008 HREADYOUT_DES  in  1  DES slave ready.
REQ-009 HRESP_DES  in  1  DES slave response.
REQ-010 HRDATA_DES  in  64  DES slave read data.
REQ-011 HREADY  out  1  muxed ready to master and to all slaves' HREADY inputs.
REQ-012 HRESP  out  1  muxed response to master (0 OKAY, 1 ERROR).
REQ-013 HRDATA  out  64  muxed read data to master.
REQ-014 ERR_COUNT  out  8  unmapped-access error count (present only under REQ-032).

Function
REQ-015 HSEL_DES SHALL be combinational: 1 when (HADDR & DES_MASK) == (DES_BASE & DES_MASK), regardless of HTRANS.
REQ-016 Data-phase select register dsel SHALL hold one of NONE, DES, DEF; it updates only on a rising edge with HREADY=1.
REQ-017 On update, dsel SHALL become DES if HSEL_DES=1, DEF if HSEL_DES=0 and HTRANS[1]=1, else NONE.
REQ-018 Built-in default-slave FSM states SHALL be IDLE, ERR1, ERR2.
REQ-019 IDLE->ERR1 when HREADY=1 and the captured transfer is DEF (HSEL_DES=0, HTRANS is NONSEQ or SEQ); otherwise stay IDLE.
REQ-020 ERR1 SHALL drive HREADY=0, HRESP=1 and go to ERR2 unconditionally next cycle.
REQ-021 ERR2 SHALL drive HREADY=1, HRESP=1; next state ERR1 if a new DEF transfer is captured this cycle, else IDLE.
REQ-022 dsel=DES: HREADY=HREADYOUT_DES, HRESP=HRESP_DES, HRDATA=HRDATA_DES, zero added latency.
REQ-023 dsel=NONE: HREADY=1, HRESP=0, HRDATA=0 (IDLE/BUSY to unmapped space gets zero-wait OKAY).
REQ-024 dsel=DEF: HREADY/HRESP per FSM state, HRDATA=0.
REQ-025 Back-to-back DES->DEF, DEF->DES and DEF->DEF transfers SHALL be accepted with no dead cycles beyond the two-cycle ERROR response.
REQ-026 While HREADY=0, dsel and the address-phase decode result SHALL NOT be sampled (master-held address is re-decoded only when HREADY=1).

Reset
REQ-027 HRESET=1 SHALL asynchronously force dsel=NONE and FSM=IDLE, regardless of clock.
REQ-028 During and immediately after reset: HREADY=1, HRESP=0, HRDATA=0, ERR_COUNT=0.
REQ-029 Reset asserted mid-ERROR (ERR1 or ERR2) SHALL abort the response; first post-reset cycle is IDLE/NONE.
REQ-030 No output SHALL take X after reset release with known inputs.

Configuration
REQ-031 Macro AHB_MUX_ERRCNT_EN SHALL select the error-counter feature.
REQ-032 With AHB_MUX_ERRCNT_EN defined: ERR_COUNT increments by 1 on every IDLE->ERR1 or ERR2->ERR1 transition, saturates at 8'hFF, clears only on reset.
REQ-033 Without AHB_MUX_ERRCNT_EN: port ERR_COUNT absent, no counter logic; all other behaviour identical.

Verification
REQ-034 NONSEQ read HADDR=32'h8000_0010, slave returns HREADYOUT_DES=1, HRDATA_DES=64'hDEAD_BEEF_0123_4567 -> HSEL_DES=1 in address phase; next cycle HREADY=1, HRESP=0, HRDATA=64'hDEAD_BEEF_0123_4567.
REQ-035 NONSEQ write HADDR=32'h0000_0000 -> HREADY=0/HRESP=1 cycle 1, HREADY=1/HRESP=1 cycle 2, then IDLE; ERR_COUNT=1 (macro on).
REQ-036 DES access with HREADYOUT_DES low 3 cycles -> HREADY low exactly 3 cycles; HADDR change during wait does not alter dsel.
REQ-037 Back-to-back NONSEQ to 32'h0000_1000 then 32'h0000_2000 -> two complete ERROR pairs, ERR2->ERR1 direct, ERR_COUNT=2.
REQ-038 HTRANS=IDLE to 32'h0000_0000 -> HREADY=1, HRESP=0, FSM stays IDLE, ERR_COUNT unchanged.
REQ-039 Assert HRESET during ERR1 -> same instant HREADY=1, HRESP=0; after release next unmapped NONSEQ gets full two-cycle ERROR.
